simon_host_bridge: RTL and testbench

Word-serial host front end for the SIMON 128/256 core. Assembles the 256-bit key and 128-bit block from 32-bit host words and drives the core's `newKey`/`newData` load handshake. It then waits for `doneData`, acknowledges with `readData`, and streams the 128-bit result back to the host as 32-bit words. It sits directly upstream and downstream of the core and owns every core control input except the core's own reset.

---
 rtl/simon_pkg.sv | 10 +
 rtl/simon_word_shifter.sv | 21 ++
 rtl/simon_host_bridge.sv | 174 +++++++++++++++++
 tb/tb_simon_host_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared sizes, host command codes and bridge states for the SIMON 128/256 host bridge.
package simon_pkg;
    localparam int DEF_N = 64;
    localparam int DEF_M = 4;
    localparam int DEF_W = 32;
    localparam int DATA_WORDS = 2 * DEF_N / DEF_W;
    localparam int KEY_WORDS = DEF_M * DEF_N / DEF_W;
    typedef enum logic [1:0] {DATA = 2'b00, KEY = 2'b01, ENC = 2'b10, DEC = 2'b11} cmd_t;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, ACK, DRAIN} state_t;
endpackage

// File: rtl/simon_word_shifter.sv
// simon_word_shifter: register that parallel-loads or shifts left by one host word.
module simon_word_shifter
    import simon_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_N,
    parameter int W = DEF_W
) (
    input  logic             clk,
    input  logic             R,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_val,
    input  logic [W-1:0]     shift_in,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (R) q <= '0;
        else if (load) q <= load_val;
        else if (shift) q <= {q[WIDTH-W-1:0], shift_in};
    end
endmodule

// File: rtl/simon_host_bridge.sv
// simon_host_bridge: word-serial host front end for the SIMON 128/256 core.
// Define SIMON_BRIDGE_WDOG_EN to abort a stalled core handshake after WDOG cycles.
module simon_host_bridge
    import simon_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M,
    parameter int W = DEF_W,
    parameter int WDOG = 1023
) (
    input  logic                clk,
    input  logic                R,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_cmd,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic                err,
    output logic                newData,
    output logic                newKey,
    output logic                enc_dec,
    output logic                readData,
    output logic [2*N-1:0]      plain,
    output logic [M-1:0][N-1:0] key,
    input  logic                ldData,
    input  logic                ldKey,
    input  logic                doneData,
    input  logic                doneKey,
    input  logic [2*N-1:0]      cipher
);
    localparam int DW = 2 * N / W;
    localparam int KW = M * N / W;
    localparam int DCW = $clog2(DW + 1);
    localparam int KCW = $clog2(KW + 1);

    state_t state, state_n;
    logic [DCW-1:0] dcnt, dcnt_n, ocnt, ocnt_n;
    logic [KCW-1:0] kcnt, kcnt_n;
    logic key_pending, pend_n, err_n, nd_n, nk_n, rd_n, ed_n, ov_n;
    logic d_shift, k_shift, o_load, o_shift, take, wd_hit, unused_ok;
    logic [M*N-1:0] key_q;
    logic [2*N-1:0] out_q;

    simon_word_shifter #(.WIDTH(2 * N), .W(W)) u_plain (
        .clk(clk), .R(R), .load(1'b0), .shift(d_shift), .load_val('0), .shift_in(in_data), .q(plain)
    );
    simon_word_shifter #(.WIDTH(M * N), .W(W)) u_key (
        .clk(clk), .R(R), .load(1'b0), .shift(k_shift), .load_val('0), .shift_in(in_data), .q(key_q)
    );
    simon_word_shifter #(.WIDTH(2 * N), .W(W)) u_out (
        .clk(clk), .R(R), .load(o_load), .shift(o_shift), .load_val(cipher), .shift_in('0), .q(out_q)
    );

    assign key = key_q;
    assign out_data = out_q[2*N-1 -: W];
    assign take = in_valid && in_ready;
    assign unused_ok = ^{doneKey, WDOG};

`ifdef SIMON_BRIDGE_WDOG_EN
    localparam int WCW = $clog2(WDOG + 1);
    logic [WCW-1:0] wd_cnt;
    logic wd_live;
    assign wd_live = state inside {LOAD, RUN, ACK};
    assign wd_hit = wd_live && (wd_cnt == WCW'(WDOG - 1));
    always_ff @(posedge clk) begin
        wd_cnt <= (R || state_n != state) ? '0 : wd_live ? wd_cnt + 1'b1 : wd_cnt;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        dcnt_n = dcnt;
        kcnt_n = kcnt;
        ocnt_n = ocnt;
        pend_n = key_pending;
        err_n = err;
        nd_n = newData;
        nk_n = newKey;
        rd_n = readData;
        ed_n = enc_dec;
        ov_n = out_valid;
        d_shift = 1'b0;
        k_shift = 1'b0;
        o_load = 1'b0;
        o_shift = 1'b0;
        case (state)
            IDLE: if (take) begin
                if (in_cmd == DATA) begin
                    d_shift = 1'b1;
                    dcnt_n = (dcnt == DCW'(DW)) ? dcnt : dcnt + 1'b1;
                end else if (in_cmd == KEY) begin
                    k_shift = 1'b1;
                    kcnt_n = (kcnt == KCW'(KW - 1)) ? '0 : kcnt + 1'b1;
                    pend_n = key_pending || (kcnt == KCW'(KW - 1));
                end else if (dcnt != DCW'(DW)) begin
                    err_n = 1'b1;
                end else begin
                    ed_n = (in_cmd == ENC);
                    dcnt_n = '0;
                    nd_n = 1'b1;
                    nk_n = key_pending;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                nd_n = newData && !ldData;
                nk_n = newKey && !ldKey;
                pend_n = key_pending && !(newKey && ldKey);
                state_n = (nd_n || nk_n) ? LOAD : RUN;
            end
            RUN: if (doneData) begin
                o_load = 1'b1;
                rd_n = 1'b1;
                state_n = ACK;
            end
            ACK: if (!doneData) begin
                rd_n = 1'b0;
                ov_n = 1'b1;
                ocnt_n = '0;
                state_n = DRAIN;
            end
            DRAIN: if (out_valid && out_ready) begin
                o_shift = 1'b1;
                ocnt_n = ocnt + 1'b1;
                ov_n = (ocnt != DCW'(DW - 1));
                state_n = (ocnt == DCW'(DW - 1)) ? IDLE : DRAIN;
            end
            default: state_n = IDLE;
        endcase
        // Timeout abandons the core handshake; any captured result is never drained.
        if (wd_hit) begin
            state_n = IDLE;
            nd_n = 1'b0;
            nk_n = 1'b0;
            rd_n = 1'b0;
            o_load = 1'b0;
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state <= IDLE;
            dcnt <= '0;
            kcnt <= '0;
            ocnt <= '0;
            key_pending <= 1'b0;
            err <= 1'b0;
            newData <= 1'b0;
            newKey <= 1'b0;
            readData <= 1'b0;
            enc_dec <= 1'b0;
            out_valid <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state <= state_n;
            dcnt <= dcnt_n;
            kcnt <= kcnt_n;
            ocnt <= ocnt_n;
            key_pending <= pend_n;
            err <= err_n;
            newData <= nd_n;
            newKey <= nk_n;
            readData <= rd_n;
            enc_dec <= ed_n;
            out_valid <= ov_n;
            in_ready <= (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_simon_host_bridge.sv
// tb_simon_host_bridge: randomized bench; a word-level host model predicts plain/key/pending state
// and a stub core returns the published SIMON 128/256 vector or a simple keyed mix otherwise.
module tb_simon_host_bridge;
    import simon_pkg::*;
    localparam int N = DEF_N, M = DEF_M, W = DEF_W, DW = DATA_WORDS, KW = KEY_WORDS;
    localparam logic [255:0] VK = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] VP = 128'h74206e69206d6f6f6d69732061207369;
    localparam logic [127:0] VC = 128'h8d2b5579afc8a3a03bf72a87efe7b868;

    logic clk = 0, R = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, err;
    logic newData, newKey, enc_dec, readData, ldData = 0, ldKey = 0, doneData = 0, doneKey = 0;
    logic [1:0] in_cmd = 0;
    logic [W-1:0] in_data = 0, out_data;
    logic [2*N-1:0] plain, cipher = 0;
    logic [M-1:0][N-1:0] key;

    logic [2*N-1:0] m_plain;
    logic [M*N-1:0] m_key, core_key = 0;
    int m_dcnt, m_kcnt, errors = 0, checks = 0;
    bit m_pend;

    simon_host_bridge #(.N(N), .M(M), .W(W), .WDOG(16)) dut (
        .clk(clk), .R(R), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err),
        .newData(newData), .newKey(newKey), .enc_dec(enc_dec), .readData(readData),
        .plain(plain), .key(key), .ldData(ldData), .ldKey(ldKey), .doneData(doneData),
        .doneKey(doneKey), .cipher(cipher)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [255:0] k, input bit enc);
        if (k == VK && enc && p == VP) return VC;
        if (k == VK && !enc && p == VC) return VP;
        return p ^ k[127:0] ^ k[255:128] ^ (enc ? 128'h0 : {128{1'b1}});
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {in_ready, out_valid, err, newData, newKey, enc_dec, readData, out_data}, 0);
        check({tag, "_plain"}, plain, 0);
        check({tag, "_key"}, key, 0);
    endtask

    task automatic model_reset();
        m_plain = 0;
        m_key = 0;
        m_dcnt = 0;
        m_kcnt = 0;
        m_pend = 0;
    endtask

    task automatic apply_reset();
        R = 1;
        in_valid = 0;
        out_ready = 0;
        ldData = 0;
        ldKey = 0;
        doneData = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        R = 0;
        @(negedge clk);
        check("reset_release_ready", in_ready, 1);
        model_reset();
    endtask

    task automatic send(input logic [1:0] cmd, input logic [W-1:0] d);
        int n;
        n = 0;
        in_valid = 1;
        in_cmd = cmd;
        in_data = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        if (cmd == DATA) begin
            m_plain = {m_plain[2*N-W-1:0], d};
            if (m_dcnt < DW) m_dcnt++;
        end else if (cmd == KEY) begin
            m_key = {m_key[M*N-W-1:0], d};
            m_kcnt = (m_kcnt + 1) % KW;
            if (m_kcnt == 0) m_pend = 1;
        end
    endtask

    task automatic run_op(input bit enc, input int ld_dly, input int lat, input bit stall, input string nm);
        logic [127:0] res, exp_plain;
        bit pend;
        int n, idx, stalls;
        exp_plain = m_plain;
        pend = m_pend;
        send(enc ? ENC : DEC, W'($urandom));
        check({nm, "_start_ready"}, in_ready, 0);
        check({nm, "_start_newData"}, newData, 1);
        check({nm, "_start_newKey"}, newKey, pend);
        check({nm, "_start_enc_dec"}, enc_dec, enc);
        check({nm, "_start_plain"}, plain, exp_plain);
        if (pend) begin
            check({nm, "_start_key"}, key, m_key);
            core_key = m_key;
            m_pend = 0;
        end
        m_dcnt = 0;
        for (int i = 0; i < ld_dly; i++) begin
            @(negedge clk);
            check({nm, "_hold_newData"}, {newData, newKey}, {1'b1, pend});
        end
        ldData = 1;
        ldKey = pend;
        @(negedge clk);
        ldData = 0;
        ldKey = 0;
        check({nm, "_ld_strobes"}, {newData, newKey}, 0);
        res = core_fn(exp_plain, core_key, enc);
        repeat (lat) @(negedge clk);
        check({nm, "_run_readData"}, {readData, out_valid}, 0);
        cipher = res;
        doneData = 1;
        @(negedge clk);
        cipher = {$urandom, $urandom, $urandom, $urandom};
        check({nm, "_ack_readData"}, readData, 1);
        check({nm, "_ack_plain"}, plain, exp_plain);
        check({nm, "_ack_key"}, key, m_key);
        check({nm, "_ack_enc_dec"}, enc_dec, enc);
        @(negedge clk);
        check({nm, "_ack_hold"}, readData, 1);
        doneData = 0;
        @(negedge clk);
        check({nm, "_drain_entry"}, {readData, out_valid}, 2'b01);
        n = 0;
        idx = 0;
        stalls = 0;
        while (idx < DW && n < 100) begin
            if (stall && idx == 2 && stalls < 3) begin
                out_ready = 0;
                stalls++;
            end else out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                check($sformatf("%s_out%0d", nm, idx), out_data, res[2*N-1-W*idx -: W]);
                idx++;
            end
            @(negedge clk);
            n++;
        end
        out_ready = 0;
        check({nm, "_drain_count"}, idx, DW);
        check({nm, "_drain_done"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: run did not finish");
        $fatal(1);
    end

    initial begin
        int nk, nd;
        model_reset();
        apply_reset();
        check("idle_err", {err, newData, newKey, readData}, 0);
        for (int i = KW - 1; i >= 0; i--) send(KEY, VK[W*i +: W]);
        for (int i = DW - 1; i >= 0; i--) send(DATA, VP[W*i +: W]);
        run_op(1, 1, 3, 0, "enc");
        for (int i = DW - 1; i >= 0; i--) send(DATA, VC[W*i +: W]);
        run_op(0, 0, 2, 0, "dec");

        for (int i = 0; i < DW - 1; i++) send(DATA, W'($urandom));
        send(ENC, 0);
        check("short_err", err, 1);
        check("short_state", {in_ready, newData}, 2'b10);
        @(negedge clk);
        check("short_no_load", {in_ready, newData, err}, 3'b101);

        apply_reset();
        for (int i = 0; i < KW; i++) send(KEY, W'($urandom));
        for (int i = 0; i < DW; i++) send(DATA, W'($urandom));
        run_op(1, 5, 2, 1, "hs");

        for (int t = 0; t < 6; t++) begin
            nk = ($urandom_range(0, 2) == 0) ? 0 : ($urandom_range(0, 1) ? KW : 3);
            nd = DW;
            while (nk + nd > 0) begin
                if (nd == 0 || (nk > 0 && $urandom_range(0, 1) == 1)) begin
                    send(KEY, W'($urandom));
                    nk--;
                end else begin
                    send(DATA, W'($urandom));
                    nd--;
                end
            end
            run_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4), 0,
                   $sformatf("rnd%0d", t));
        end
        check("final_err", err, 0);

`ifdef SIMON_BRIDGE_WDOG_EN
        apply_reset();
        for (int i = 0; i < DW; i++) send(DATA, W'($urandom));
        send(ENC, 0);
        ldData = 1;
        @(negedge clk);
        ldData = 0;
        repeat (15) @(negedge clk);
        check("wd_before", {err, in_ready}, 0);
        @(negedge clk);
        check("wd_fire", {err, in_ready, newData, readData, out_valid}, 5'b11000);
        for (int i = 0; i < DW; i++) send(DATA, W'($urandom));
        send(DEC, 0);
        ldData = 1;
        @(negedge clk);
        ldData = 0;
        @(negedge clk);
        R = 1;
        @(negedge clk);
        check_zero("run_reset");
        R = 0;
        @(negedge clk);
        check("run_reset_ready", in_ready, 1);
        model_reset();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
